clz_share_arb: RTL and testbench
================================

Name: clz_share_arb

Overview:
- Shares one combinational count-leading-zeros/ones datapath between NUM_REQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- The single shared result is registered into a one-entry output slot with a valid/ready response channel, tagged with the requester ID.
- Sits between the normalization/scalar units that need CLZ/CLO and the shared counter, so only one counter instance is built.

Parameters:
- NUM_REQ, 4: number of requesters; 2..16.
- WI_SZ, 32: operand width; power of two, at least 2.
- WO_SZ, $clog2(WI_SZ)+1: count width; wide enough to hold WI_SZ.
- ID_SZ, $clog2(NUM_REQ): requester ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_data  in  NUM_REQ*WI_SZ  operands; requester i at [i*WI_SZ +: WI_SZ]
- req_mode  in  NUM_REQ  per-requester mode; 0 = count leading zeros, 1 = count leading ones
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_SZ  requester index of the result
- rsp_count  out  WO_SZ  leading zero/one count, range 0..WI_SZ
- rsp_all  out  1  operand was entirely zeros (mode 0) or entirely ones (mode 1)

Behaviour:
- Reset (async assert, sync deassert in use): rsp_valid=0, rsp_id=0, rsp_count=0, rsp_all=0, req_ready=0, rr pointer=0, FSM=EMPTY.
- FSM states:
  - EMPTY: output slot free.
  - FULL: slot holds an unconsumed result.
- Slot may load ("can_load") when FSM=EMPTY, or when FSM=FULL and rsp_ready=1 (same-cycle drain and refill).
- Arbitration:
  - When can_load and any req_valid is high, grant the first valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - req_ready is combinational and one-hot on the granted index; it is all-zero when nothing is granted.
  - req_ready never depends on req_valid of other requesters beyond the grant selection.
- On a grant (handshake req_valid[g] & req_ready[g]):
  - Operand x = req_mode[g] ? ~req_data[g] : req_data[g].
  - rsp_count <= number of leading zeros of x, MSB first; equals WI_SZ when x==0.
  - rsp_all <= (x==0); rsp_id <= g; rsp_valid <= 1; FSM -> FULL.
  - rr pointer <= (g+1) mod NUM_REQ.
- Latency: result appears the cycle after the handshake.
- Throughput: one result per cycle while rsp_ready stays high.
- FULL with rsp_ready=1 and no grant: rsp_valid <= 0, FSM -> EMPTY; rsp_id/count/all hold their last values.
- FULL with rsp_ready=0: all outputs hold stable; req_ready=0 (backpressure).
- The rr pointer advances only on a grant, never on idle cycles.
- Requesters must hold req_valid/req_data/req_mode stable until accepted. The block does not check this; dropped requests are undefined.
- Reset mid-operation discards any held result; no response is ever emitted for it.
- A single requester that is continuously valid is granted every cycle once the slot drains each cycle.
- Count width: the count is computed in WO_SZ bits; values WI_SZ+1 and above are unreachable.

Optional Feature:
- Macro: CLZ_SHARE_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt, width NUM_REQ*16: one 16-bit saturating grant counter per requester.
  - A counter increments on each grant to its requester and sticks at 16'hFFFF.
  - Reset value 0.
  - Adds input stats_clr (1 bit); stats_clr=1 synchronously zeroes all counters, and clear wins over a same-cycle increment.
- Not defined: neither port exists and no counter logic is built. Functional behaviour is otherwise identical.

Test Plan:
- Reset, then NUM_REQ=4, WI_SZ=32; req 2 only, data 32'h0000_1000, mode 0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=2, rsp_count=19, rsp_all=0; rr pointer then 3.
- Boundaries:
  - data 0, mode 0 -> rsp_count=32, rsp_all=1.
  - data 32'hFFFF_FFFF, mode 1 -> count 32, all=1.
  - data 32'h8000_0000, mode 0 -> count 0.
  - data 32'hF000_0000, mode 1 -> count 4.
- All four req_valid high continuously, rsp_ready=1, pointer 0 -> grants 0,1,2,3,0,... one per cycle with back-to-back rsp_valid; each ID appears exactly once per 4 results.
- Result held with rsp_ready=0 for 5 cycles while req 1 is valid -> req_ready=0 and outputs stable throughout; when rsp_ready rises, same cycle req_ready[1]=1, and the next cycle returns the req 1 result (drain and refill).
- Assert rst asynchronously while FULL -> rsp_valid drops immediately; after release with no requests, no stale response appears; first grant goes to the lowest valid index from pointer 0.
- CLZ_SHARE_ARB_STATS_EN defined:
  - 3 grants to req 0 -> grant_cnt[15:0]=3.
  - Force 70000 grants -> 16'hFFFF.
  - stats_clr together with a grant -> 0.

Source files
------------

// File: rtl/clz_share_arb.sv
// clz_share_arb -- one count-leading-zeros/ones datapath shared by NUM_REQ
// requesters through a round-robin arbiter, with a one-entry registered
// result slot on a valid/ready response channel.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot or 0)
//   req_data            packed operands, requester i at [i*WI_SZ +: WI_SZ]
//   req_mode            per-requester mode: 0 = CLZ, 1 = CLO
//   rsp_valid/rsp_ready result handshake
//   rsp_id              requester index of the held result
//   rsp_count           leading zero/one count, 0..WI_SZ
//   rsp_all             operand was all zeros (CLZ) / all ones (CLO)
//
// Optional build macro CLZ_SHARE_ARB_STATS_EN adds:
//   stats_clr           synchronous clear of all grant counters
//   grant_cnt           NUM_REQ x 16-bit saturating grant counters
module clz_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WI_SZ   = 32,
  parameter int WO_SZ   = $clog2(WI_SZ) + 1,
  parameter int ID_SZ   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WI_SZ-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_mode,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_SZ-1:0]         rsp_id,
  output logic [WO_SZ-1:0]         rsp_count,
  output logic                     rsp_all
`ifdef CLZ_SHARE_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ID_SZ-1:0] r_ptr;
  logic [ID_SZ-1:0] r_id;
  logic [WO_SZ-1:0] r_count;
  logic             r_all;

  logic [WI_SZ-1:0] w_opnd [NUM_REQ];
  logic             w_can_load;
  logic             w_found;
  logic             w_grant;
  logic [ID_SZ-1:0] w_gnt_idx;
  logic [ID_SZ-1:0] w_ptr_next;
  logic [WI_SZ-1:0] w_x;
  logic [WO_SZ-1:0] w_clz;
  logic             w_all;

  // Unpack the flat operand bus.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_opnd[gi] = req_data[gi*WI_SZ +: WI_SZ];
    end
  endgenerate

  // A full slot can be refilled in the same cycle it is drained.
  assign w_can_load = (r_state == S_EMPTY) || rsp_ready;

  // Round-robin search: first valid requester at or after r_ptr, wrapping.
  // The index is one bit wider so ptr+k can exceed NUM_REQ before wrap.
  always_comb begin
    logic [ID_SZ:0] v_idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    v_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = {1'b0, r_ptr} + (ID_SZ+1)'(k);
      if (v_idx >= (ID_SZ+1)'(NUM_REQ))
        v_idx = v_idx - (ID_SZ+1)'(NUM_REQ);
      if (!w_found && req_valid[ID_SZ'(v_idx)]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_SZ'(v_idx);
      end
    end
  end

  assign w_grant = w_can_load && w_found;

  always_comb begin
    req_ready = '0;
    if (w_grant)
      req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_ptr_next = (w_gnt_idx == ID_SZ'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // CLO is CLZ of the inverted operand.
  assign w_x   = req_mode[w_gnt_idx] ? ~w_opnd[w_gnt_idx] : w_opnd[w_gnt_idx];
  assign w_all = (w_x == '0);

  // Scan LSB to MSB; the highest set bit is the last to overwrite.
  always_comb begin
    w_clz = WO_SZ'(WI_SZ);
    for (int i = 0; i < WI_SZ; i++) begin
      if (w_x[i])
        w_clz = WO_SZ'(WI_SZ - 1 - i);
    end
  end

  // Slot state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_grant) w_state_next = S_FULL;
      S_FULL: begin
        if (w_grant)
          w_state_next = S_FULL;
        else if (rsp_ready)
          w_state_next = S_EMPTY;
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // Result payload and pointer only move on a grant; they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_count <= '0;
      r_all   <= 1'b0;
    end else if (w_grant) begin
      r_ptr   <= w_ptr_next;
      r_id    <= w_gnt_idx;
      r_count <= w_clz;
      r_all   <= w_all;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_id    = r_id;
  assign rsp_count = r_count;
  assign rsp_all   = r_all;

`ifdef CLZ_SHARE_ARB_STATS_EN
  // Per-requester saturating grant counters; clear beats increment.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] r_gcnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_gcnt <= '0;
        else if (stats_clr)
          r_gcnt <= '0;
        else if (w_grant && (w_gnt_idx == ID_SZ'(gi)) && (r_gcnt != 16'hFFFF))
          r_gcnt <= r_gcnt + 16'd1;
      end
      assign grant_cnt[gi*16 +: 16] = r_gcnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_clz_share_arb.sv
// Directed testbench for clz_share_arb (NUM_REQ=4, WI_SZ=32).
// Build with CLZ_SHARE_ARB_STATS_EN defined to also exercise grant counters.
module tb_clz_share_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [3:0]   req_mode;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [5:0]   rsp_count;
  logic         rsp_all;
  logic         stats_clr;
`ifdef CLZ_SHARE_ARB_STATS_EN
  logic [63:0]  grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  clz_share_arb #(.NUM_REQ(4), .WI_SZ(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_all   (rsp_all)
`ifdef CLZ_SHARE_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated request from requester idx; result checked next cycle.
  task automatic do_single(input int idx, input logic [31:0] d, input logic m,
                           input int ecnt, input logic eall);
    @(negedge clk);
    req_data[idx*32 +: 32] = d;
    req_mode[idx]          = m;
    req_valid              = 4'b0001 << idx;
    #1 check("single_ready", 64'(req_ready), 64'(4'b0001 << idx));
    @(negedge clk);
    check("single_valid", 64'(rsp_valid), 64'(1));
    check("single_id",    64'(rsp_id),    64'(idx));
    check("single_count", 64'(rsp_count), 64'(ecnt));
    check("single_all",   64'(rsp_all),   64'(eall));
    $display("single req=%0d data=%08h mode=%0d -> count=%0d all=%0d", idx, d, m, rsp_count, rsp_all);
    req_valid = 4'b0000;
  endtask

  int exp_cnt [4];
  logic exp_all [4];
  int g;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_mode  = '0;
    rsp_ready = 1'b0;
    stats_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(rsp_valid), 64'(0));
    check("rst_id",    64'(rsp_id),    64'(0));
    check("rst_count", 64'(rsp_count), 64'(0));
    check("rst_all",   64'(rsp_all),   64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    rst       = 1'b0;
    rsp_ready = 1'b1;

    // 0x1000: highest set bit 12 -> 19 leading zeros; pointer moves to 3.
    do_single(2, 32'h0000_1000, 1'b0, 19, 1'b0);

    // All requesters valid: grants 3,0,1,2,3,0,1,2,3 back to back.
    exp_cnt[0] = 31; exp_all[0] = 1'b0;  // 0x00000001, CLZ
    exp_cnt[1] = 0;  exp_all[1] = 1'b0;  // 0x80000000, CLZ
    exp_cnt[2] = 4;  exp_all[2] = 1'b0;  // 0xF0000000, CLO
    exp_cnt[3] = 32; exp_all[3] = 1'b1;  // 0x00000000, CLZ
    @(negedge clk);
    req_data  = {32'h0000_0000, 32'hF000_0000, 32'h8000_0000, 32'h0000_0001};
    req_mode  = 4'b0100;
    req_valid = 4'b1111;
    g = 3;
    for (int k = 0; k < 9; k++) begin
      #1 check("rr_ready", 64'(req_ready), 64'(4'b0001 << g));
      @(negedge clk);
      check("rr_valid", 64'(rsp_valid), 64'(1));
      check("rr_id",    64'(rsp_id),    64'(g));
      check("rr_count", 64'(rsp_count), 64'(exp_cnt[g]));
      check("rr_all",   64'(rsp_all),   64'(exp_all[g]));
      $display("rr step=%0d id=%0d count=%0d all=%0d", k, rsp_id, rsp_count, rsp_all);
      g = (g + 1) % 4;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    check("drain_valid", 64'(rsp_valid), 64'(0));
    check("drain_id",    64'(rsp_id),    64'(3));
    check("drain_count", 64'(rsp_count), 64'(32));
    $display("drain valid=%0d id=%0d count=%0d", rsp_valid, rsp_id, rsp_count);

    // Boundary operands.
    do_single(1, 32'hFFFF_FFFF, 1'b1, 32, 1'b1);
    do_single(0, 32'h0000_0000, 1'b0, 32, 1'b1);
    do_single(3, 32'h8000_0000, 1'b0, 0,  1'b0);
    do_single(2, 32'hF000_0000, 1'b1, 4,  1'b0);

    // Backpressure: slot holds id 2 / count 4 while req 1 waits.
    rsp_ready            = 1'b0;
    req_data[32 +: 32]   = 32'h0000_FFFF;
    req_mode[1]          = 1'b0;
    req_valid            = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'(0));
      check("bp_valid", 64'(rsp_valid), 64'(1));
      check("bp_id",    64'(rsp_id),    64'(2));
      check("bp_count", 64'(rsp_count), 64'(4));
      $display("backpressure cycle=%0d ready=%b id=%0d count=%0d", k, req_ready, rsp_id, rsp_count);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("refill_ready", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    check("refill_valid", 64'(rsp_valid), 64'(1));
    check("refill_id",    64'(rsp_id),    64'(1));
    check("refill_count", 64'(rsp_count), 64'(16));
    check("refill_all",   64'(rsp_all),   64'(0));
    $display("refill id=%0d count=%0d", rsp_id, rsp_count);
    req_valid = 4'b0000;

    // Asynchronous reset mid-cycle while FULL.
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(rsp_valid), 64'(0));
    check("arst_ready", 64'(req_ready), 64'(0));
    check("arst_count", 64'(rsp_count), 64'(0));
    $display("async reset valid=%0d count=%0d", rsp_valid, rsp_count);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(rsp_valid), 64'(0));
    end
    req_valid = 4'b1100;
    #1 check("post_rst_ready", 64'(req_ready), 64'(4'b0100));
    @(negedge clk);
    check("post_rst_id",    64'(rsp_id),    64'(2));
    check("post_rst_count", 64'(rsp_count), 64'(4));
    $display("post reset grant id=%0d count=%0d", rsp_id, rsp_count);
    req_valid = 4'b0000;

`ifdef CLZ_SHARE_ARB_STATS_EN
    @(negedge clk);
    req_data[31:0] = 32'h0000_0001;
    req_mode[0]    = 1'b0;
    req_valid      = 4'b0001;
    repeat (3) @(negedge clk);
    req_valid = 4'b0000;
    #1 check("stats_three", 64'(grant_cnt[15:0]), 64'(3));
    $display("stats after 3 grants cnt0=%0d", grant_cnt[15:0]);
    req_valid = 4'b0001;
    repeat (70000) @(negedge clk);
    #1 check("stats_sat", 64'(grant_cnt[15:0]), 64'(16'hFFFF));
    $display("stats after 70003 grants cnt0=%0h", grant_cnt[15:0]);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    req_valid = 4'b0000;
    #1 check("stats_clr", 64'(grant_cnt[15:0]), 64'(0));
    $display("stats after clear with grant cnt0=%0d", grant_cnt[15:0]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
